// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer
// Ordered power-up and reverse-order power-down of the PDN supply rails VDD1..VDDn.
// Each rail must show SETTLE_CYCLES consecutive power-good cycles before the next
// rail is enabled, and must settle within TIMEOUT_CYCLES of its enable. Loss of
// power-good on an already settled rail, or a timeout, latches a sticky fault.
// Every output comes straight from a flop.
module pdn_rail_sequencer #(
   parameter int NUM_RAILS      = 6,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwr_req,
   input  logic                 fault_clr,
   input  logic [NUM_RAILS-1:0] rail_pg,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic                 all_good,
   output logic                 busy,
   output logic                 fault,
   output logic [2:0]           fault_rail
);

   localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

   localparam logic [2:0] ST_OFF   = 3'd0;
   localparam logic [2:0] ST_UP    = 3'd1;
   localparam logic [2:0] ST_ON    = 3'd2;
   localparam logic [2:0] ST_DOWN  = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RAILS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

   logic [2:0]           state, state_nx;
   logic [IDX_W-1:0]     idx, idx_nx;
   logic [CNT_W-1:0]     scnt, scnt_nx;
   logic [CNT_W-1:0]     tcnt, tcnt_nx;
   logic [NUM_RAILS-1:0] rail_en_nx;
   logic                 fault_nx;
   logic [2:0]           fault_rail_nx;
   logic [NUM_RAILS-1:0] below_mask;
   logic [NUM_RAILS-1:0] below_drop;
   logic [NUM_RAILS-1:0] any_drop;
   logic                 adv;
   logic                 time_up;

   // Counters hold at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
   endfunction

   // Index of the lowest set bit; lowest failing rail wins when several drop together.
   function automatic logic [2:0] low_idx(input logic [NUM_RAILS-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int k = NUM_RAILS - 1; k >= 0; k--) begin
         if (v[k]) r = 3'(k);
      end
      return r;
   endfunction

   // Mask of rails that have already settled (indices strictly below idx).
   always_comb begin
      below_mask = '0;
      for (int k = 0; k < NUM_RAILS; k++) begin
         below_mask[k] = (IDX_W'(k) < idx);
      end
   end

   assign below_drop = ~rail_pg & below_mask;
   assign any_drop   = ~rail_pg;
   assign adv        = (scnt == SETTLE_LAST) && rail_pg[idx];
   assign time_up    = (tcnt == TIMEOUT_LAST) && !adv;

   // Next-state and next-output decode for the sequencer.
   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      scnt_nx       = scnt;
      tcnt_nx       = tcnt;
      rail_en_nx    = rail_en;
      fault_nx      = fault;
      fault_rail_nx = fault_rail;
      case (state)
         ST_OFF: begin
            idx_nx     = '0;
            scnt_nx    = '0;
            tcnt_nx    = '0;
            rail_en_nx = '0;
            if (pwr_req) begin
               state_nx   = ST_UP;
               rail_en_nx = NUM_RAILS'(1);
            end
         end
         ST_UP: begin
            if (|below_drop) begin
               // A settled rail lost power-good: shut everything down at once.
               state_nx      = ST_FAULT;
               rail_en_nx    = '0;
               fault_nx      = 1'b1;
               fault_rail_nx = low_idx(below_drop);
               scnt_nx       = '0;
               tcnt_nx       = '0;
            end else if (time_up) begin
               state_nx      = ST_FAULT;
               rail_en_nx    = '0;
               fault_nx      = 1'b1;
               fault_rail_nx = 3'(idx);
               scnt_nx       = '0;
               tcnt_nx       = '0;
            end else if (!pwr_req) begin
               // Abort the ramp: drop the rail being ramped, then unwind the rest.
               state_nx        = ST_DOWN;
               rail_en_nx[idx] = 1'b0;
               scnt_nx         = '0;
               tcnt_nx         = '0;
            end else if (adv) begin
               scnt_nx = '0;
               tcnt_nx = '0;
               if (idx == IDX_LAST) begin
                  state_nx = ST_ON;
               end else begin
                  idx_nx             = idx + IDX_ONE;
                  rail_en_nx[idx_nx] = 1'b1;
               end
            end else begin
               scnt_nx = rail_pg[idx] ? sat_inc(scnt) : '0;
               tcnt_nx = sat_inc(tcnt);
            end
         end
         ST_ON: begin
            if (|any_drop) begin
               state_nx      = ST_FAULT;
               rail_en_nx    = '0;
               fault_nx      = 1'b1;
               fault_rail_nx = low_idx(any_drop);
            end else if (!pwr_req) begin
               state_nx             = ST_DOWN;
               idx_nx               = IDX_LAST;
               rail_en_nx[IDX_LAST] = 1'b0;
               scnt_nx              = '0;
            end
         end
         ST_DOWN: begin
            // scnt doubles as the per-rail hold timer; power-good is not consulted.
            if (scnt == SETTLE_LAST) begin
               scnt_nx = '0;
               if (idx == '0) begin
                  state_nx = ST_OFF;
               end else begin
                  idx_nx             = idx - IDX_ONE;
                  rail_en_nx[idx_nx] = 1'b0;
               end
            end else begin
               scnt_nx = sat_inc(scnt);
            end
         end
         ST_FAULT: begin
            rail_en_nx = '0;
            if (fault_clr && !pwr_req) begin
               state_nx      = ST_OFF;
               fault_nx      = 1'b0;
               fault_rail_nx = 3'd0;
               idx_nx        = '0;
               scnt_nx       = '0;
               tcnt_nx       = '0;
            end
         end
         default: begin
            state_nx   = ST_OFF;
            rail_en_nx = '0;
            idx_nx     = '0;
            scnt_nx    = '0;
            tcnt_nx    = '0;
         end
      endcase
   end

   // State, counters and all outputs registered; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         idx        <= '0;
         scnt       <= '0;
         tcnt       <= '0;
         rail_en    <= '0;
         all_good   <= 1'b0;
         busy       <= 1'b0;
         fault      <= 1'b0;
         fault_rail <= 3'd0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         scnt       <= scnt_nx;
         tcnt       <= tcnt_nx;
         rail_en    <= rail_en_nx;
         all_good   <= (state_nx == ST_ON);
         busy       <= (state_nx == ST_UP) || (state_nx == ST_DOWN);
         fault      <= fault_nx;
         fault_rail <= fault_rail_nx;
      end
   end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// tb_pdn_rail_sequencer
// Vector table, directed ramp/fault/reset sequences, and a randomized run compared
// against a rail-count based reference model of the sequencer.
module tb_pdn_rail_sequencer;

   localparam int N  = 6;
   localparam int SC = 4;
   localparam int TC = 32;

   localparam int M_OFF   = 0;
   localparam int M_UP    = 1;
   localparam int M_ON    = 2;
   localparam int M_DOWN  = 3;
   localparam int M_FAULT = 4;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         pwr_req   = 1'b0;
   logic         fault_clr = 1'b0;
   logic [N-1:0] rail_pg   = '0;
   logic [N-1:0] rail_en;
   logic         all_good;
   logic         busy;
   logic         fault;
   logic [2:0]   fault_rail;

   int checks   = 0;
   int failures = 0;

   bit           follow   = 1'b0;
   bit           model_on = 1'b0;
   logic [N-1:0] pg_mask  = '1;

   // reference model: which phase, which rail is active, how many rails are enabled
   int m_mode, m_rail, m_run, m_age, m_n_on, m_frail;
   bit m_fault;

   typedef struct {
      logic         req;
      logic         clr;
      logic [N-1:0] pg;
      logic [N-1:0] en;
      logic         ag;
      logic         bz;
      logic         f;
      logic [2:0]   fr;
   } vec_t;

   vec_t tbl[25];

   always #5 clk = ~clk;

   pdn_rail_sequencer #(
      .NUM_RAILS(N), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC), .CNT_W(9)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .fault_clr(fault_clr),
      .rail_pg(rail_pg), .rail_en(rail_en), .all_good(all_good), .busy(busy),
      .fault(fault), .fault_rail(fault_rail)
   );

   function automatic logic [N-1:0] therm(input int n);
      logic [N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) if (k < n) v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [11:0] pk(input logic [N-1:0] en, input logic ag,
                                      input logic bz, input logic f, input logic [2:0] fr);
      return {en, ag, bz, f, fr};
   endfunction

   function automatic vec_t mk(input logic req, input logic clr, input logic [N-1:0] pg,
                               input logic [N-1:0] en, input logic bz);
      vec_t v;
      v.req = req; v.clr = clr; v.pg = pg; v.en = en;
      v.ag = 1'b0; v.bz = bz; v.f = 1'b0; v.fr = 3'd0;
      return v;
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {rail_en, all_good, busy, fault, fault_rail};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got en=%b ag=%b busy=%b fault=%b frail=%0d, want en=%b ag=%b busy=%b fault=%b frail=%0d",
                  name, act[11:6], act[5], act[4], act[3], act[2:0],
                  exp[11:6], exp[5], exp[4], exp[3], exp[2:0]);
      end
   endtask

   task automatic model_reset();
      m_mode = M_OFF; m_rail = 0; m_run = 0; m_age = 0; m_n_on = 0;
      m_frail = 0; m_fault = 1'b0;
   endtask

   task automatic go_fault(input int r);
      m_mode = M_FAULT; m_n_on = 0; m_fault = 1'b1; m_frail = r;
   endtask

   task automatic model_step();
      int drop;
      bit settled;
      drop = -1;
      case (m_mode)
         M_OFF: if (pwr_req) begin
            m_mode = M_UP; m_rail = 0; m_n_on = 1; m_run = 0; m_age = 0;
         end
         M_UP: begin
            for (int j = m_rail - 1; j >= 0; j--) if (!rail_pg[j]) drop = j;
            settled = rail_pg[m_rail] && (m_run + 1 == SC);
            if (drop >= 0) go_fault(drop);
            else if ((m_age + 1 == TC) && !settled) go_fault(m_rail);
            else if (!pwr_req) begin
               m_mode = M_DOWN; m_n_on = m_rail; m_run = 0;
            end else if (settled) begin
               m_run = 0;
               if (m_rail == N - 1) m_mode = M_ON;
               else begin
                  m_rail++; m_n_on = m_rail + 1; m_age = 0;
               end
            end else begin
               m_run = rail_pg[m_rail] ? m_run + 1 : 0;
               m_age++;
            end
         end
         M_ON: begin
            for (int j = N - 1; j >= 0; j--) if (!rail_pg[j]) drop = j;
            if (drop >= 0) go_fault(drop);
            else if (!pwr_req) begin
               m_mode = M_DOWN; m_rail = N - 1; m_n_on = N - 1; m_run = 0;
            end
         end
         M_DOWN: begin
            m_run++;
            if (m_run == SC) begin
               m_run = 0;
               if (m_rail == 0) m_mode = M_OFF;
               else begin
                  m_rail--; m_n_on = m_rail;
               end
            end
         end
         default: if (fault_clr && !pwr_req) begin
            m_mode = M_OFF; m_fault = 1'b0; m_frail = 0;
         end
      endcase
   endtask

   function automatic logic [11:0] model_outs();
      return pk(therm(m_n_on), m_mode == M_ON, (m_mode == M_UP) || (m_mode == M_DOWN),
                m_fault, 3'(m_frail));
   endfunction

   task automatic tick();
      @(posedge clk);
      if (model_on) model_step();
      @(negedge clk);
      if (follow) rail_pg = rail_en & pg_mask;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pwr_req = 1'b0; fault_clr = 1'b0; rail_pg = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] pg;
      int stuck;

      // vector table: glitch on rail 0, abort at rail 1, re-request during DOWN, short ramp abort
      tbl[0]  = mk(0, 1, 6'h00, 6'h00, 0);
      tbl[1]  = mk(1, 0, 6'h00, 6'h01, 1);
      tbl[2]  = mk(1, 0, 6'h01, 6'h01, 1);
      tbl[3]  = mk(1, 0, 6'h01, 6'h01, 1);
      tbl[4]  = mk(1, 0, 6'h00, 6'h01, 1);
      tbl[5]  = mk(1, 0, 6'h01, 6'h01, 1);
      tbl[6]  = mk(1, 0, 6'h01, 6'h01, 1);
      tbl[7]  = mk(1, 0, 6'h01, 6'h01, 1);
      tbl[8]  = mk(1, 0, 6'h01, 6'h03, 1);
      tbl[9]  = mk(1, 0, 6'h03, 6'h03, 1);
      tbl[10] = mk(0, 0, 6'h03, 6'h01, 1);
      for (int i = 11; i <= 13; i++) tbl[i] = mk(1, (i == 12), 6'h00, 6'h01, 1);
      for (int i = 14; i <= 17; i++) tbl[i] = mk(1, 0, 6'h00, 6'h00, 1);
      tbl[18] = mk(1, 0, 6'h00, 6'h00, 0);
      tbl[19] = mk(1, 0, 6'h00, 6'h01, 1);
      for (int i = 20; i <= 23; i++) tbl[i] = mk(0, 0, 6'h00, 6'h00, 1);
      tbl[24] = mk(0, 0, 6'h00, 6'h00, 0);

      do_reset();
      check("reset_state", pk('0, 0, 0, 0, 3'd0));

      for (int i = 0; i < 25; i++) begin
         pwr_req = tbl[i].req; fault_clr = tbl[i].clr; rail_pg = tbl[i].pg;
         tick();
         check($sformatf("vec%0d", i), pk(tbl[i].en, tbl[i].ag, tbl[i].bz, tbl[i].f, tbl[i].fr));
      end
      fault_clr = 1'b0;

      // full ramp with power-good following the enables, then power-down
      do_reset();
      follow = 1'b1; pg_mask = '1;
      pwr_req = 1'b1;
      for (int t = 0; t <= 24; t++) begin
         tick();
         check($sformatf("ramp_t%0d", t),
               pk(therm((t / SC + 1 > N) ? N : t / SC + 1), t >= N * SC, t < N * SC, 0, 3'd0));
      end
      pwr_req = 1'b0;
      for (int t = 0; t <= 24; t++) begin
         tick();
         check($sformatf("down_t%0d", t),
               pk(therm((N - 1 - t / SC < 0) ? 0 : N - 1 - t / SC), 0, t < N * SC, 0, 3'd0));
      end

      // rail 2 never reports power-good: timeout, then fault_clr handling
      do_reset();
      follow = 1'b1; pg_mask = ~6'b000100;
      pwr_req = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         tick();
         if (t == 8)  check("to_rail2_on", pk(6'b000111, 0, 1, 0, 3'd0));
         if (t == 39) check("to_before",   pk(6'b000111, 0, 1, 0, 3'd0));
         if (t == 40) check("to_fault",    pk(6'b000000, 0, 0, 1, 3'd2));
      end
      fault_clr = 1'b1;
      tick();
      check("to_clr_ignored", pk(6'b000000, 0, 0, 1, 3'd2));
      pwr_req = 1'b0;
      tick();
      check("to_clr_off", pk(6'b000000, 0, 0, 0, 3'd0));
      fault_clr = 1'b0;

      // single-cycle power-good glitch on rail 3 during its settle window
      do_reset();
      follow = 1'b1; pg_mask = '1;
      pwr_req = 1'b1;
      for (int t = 0; t <= 26; t++) begin
         tick();
         if (t == 13) rail_pg[3] = 1'b0;
         if (t == 17) check("gl_hold",  pk(6'b001111, 0, 1, 0, 3'd0));
         if (t == 18) check("gl_adv",   pk(6'b011111, 0, 1, 0, 3'd0));
         if (t == 25) check("gl_nearl", pk(6'b111111, 0, 1, 0, 3'd0));
         if (t == 26) check("gl_on",    pk(6'b111111, 1, 0, 0, 3'd0));
      end

      // two rails drop in ON while pwr_req falls: fault wins, lowest rail reported
      follow = 1'b0;
      rail_pg = 6'b101101; pwr_req = 1'b0;
      tick();
      check("multi_drop", pk(6'b000000, 0, 0, 1, 3'd1));
      fault_clr = 1'b1;
      tick();
      check("multi_clr", pk(6'b000000, 0, 0, 0, 3'd0));
      fault_clr = 1'b0;

      // asynchronous reset while ramping rail 3
      do_reset();
      follow = 1'b1; pg_mask = '1;
      pwr_req = 1'b1;
      for (int t = 0; t <= 13; t++) tick();
      check("ar_idx3", pk(6'b001111, 0, 1, 0, 3'd0));
      #2 rst_n = 1'b0;
      #1 check("ar_async", pk(6'b000000, 0, 0, 0, 3'd0));
      @(negedge clk);
      rst_n = 1'b1;
      rail_pg = '0;
      tick();
      check("ar_restart", pk(6'b000001, 0, 1, 0, 3'd0));
      repeat (SC) tick();
      check("ar_rail1", pk(6'b000011, 0, 1, 0, 3'd0));

      // randomized run against the reference model
      follow = 1'b0; model_on = 1'b1;
      do_reset();
      pwr_req = 1'b1;
      stuck = N + 3;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 39) == 0) pwr_req = ~pwr_req;
         fault_clr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 299) == 0) stuck = int'($urandom_range(0, 9));
         pg = therm(m_n_on);
         if (stuck < N) pg[stuck] = 1'b0;
         for (int b = 0; b < N; b++) if ($urandom_range(0, 96) == 0) pg[b] = ~pg[b];
         rail_pg = pg;
         tick();
         check($sformatf("rand%0d", c), model_outs());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
